// File: rtl/mips_multicycle_ctrl.sv
// Moore FSM controller for the multicycle MIPS datapath: decodes IR opcode/funct
// into ALU and datapath controls, counts retired instructions, flags bad encodings.
module mips_multicycle_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic             Zero,
   output logic [2:0]       ALUctrl,
   output logic             ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [1:0]       PCSrc,
   output logic             IorD,
   output logic             IRWrite,
   output logic             MemWrite,
   output logic             RegWrite,
   output logic             RegDst,
   output logic             MemtoReg,
   output logic             PCEn,
   output logic             instr_done,
   output logic             illegal,
   output logic [3:0]       state,
   output logic [CNT_W-1:0] instr_count
);

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      EXEC   = 4'd6,
      ALUWB  = 4'd7,
      BRANCH = 4'd8,
      ADDIEX = 4'd9,
      ADDIWB = 4'd10,
      JUMP   = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   function automatic logic funct_supported(input logic [5:0] f);
      case (f)
         6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: funct_supported = 1'b1;
         default:                                               funct_supported = 1'b0;
      endcase
   endfunction

   function automatic logic [2:0] funct_aluctrl(input logic [5:0] f);
      case (f)
         6'b100000: funct_aluctrl = ALU_ADD;
         6'b100010: funct_aluctrl = ALU_SUB;
         6'b100100: funct_aluctrl = ALU_AND;
         6'b100101: funct_aluctrl = ALU_OR;
         6'b101010: funct_aluctrl = ALU_SLT;
         default:   funct_aluctrl = ALU_ADD;
      endcase
   endfunction

   state_t           state_r;
   state_t           state_nxt_s;
   logic [CNT_W-1:0] instr_count_r;
   logic             illegal_s;
   logic [2:0]       aluctrl_s;
   logic             alusrca_s;
   logic [1:0]       alusrcb_s;
   logic [1:0]       pcsrc_s;
   logic             iord_s;
   logic             irwrite_s;
   logic             memwrite_s;
   logic             regwrite_s;
   logic             regdst_s;
   logic             memtoreg_s;
   logic             pcwrite_s;
   logic             branch_s;
   logic             instr_done_s;

   // Next-state selection; DECODE also detects unsupported encodings.
   always_comb begin
      state_nxt_s = FETCH;
      illegal_s   = 1'b0;
      case (state_r)
         FETCH:  state_nxt_s = DECODE;
         DECODE: begin
            case (opcode)
               OP_LW, OP_SW: state_nxt_s = MEMADR;
               OP_RTYPE: begin
                  if (funct_supported(funct)) begin
                     state_nxt_s = EXEC;
                  end else begin
                     state_nxt_s = FETCH;
                     illegal_s   = 1'b1;
                  end
               end
               OP_BEQ:  state_nxt_s = BRANCH;
               OP_ADDI: state_nxt_s = ADDIEX;
               OP_J:    state_nxt_s = JUMP;
               default: begin
                  state_nxt_s = FETCH;
                  illegal_s   = 1'b1;
               end
            endcase
         end
         MEMADR: begin
            if (opcode == OP_SW) begin
               state_nxt_s = MEMWR;
            end else begin
               state_nxt_s = MEMRD;
            end
         end
         MEMRD:   state_nxt_s = MEMWB;
         EXEC:    state_nxt_s = ALUWB;
         ADDIEX:  state_nxt_s = ADDIWB;
         default: state_nxt_s = FETCH;
      endcase
   end

   // Moore output decode from the state register.
   always_comb begin
      aluctrl_s    = ALU_ADD;
      alusrca_s    = 1'b0;
      alusrcb_s    = 2'b00;
      pcsrc_s      = 2'b00;
      iord_s       = 1'b0;
      irwrite_s    = 1'b0;
      memwrite_s   = 1'b0;
      regwrite_s   = 1'b0;
      regdst_s     = 1'b0;
      memtoreg_s   = 1'b0;
      pcwrite_s    = 1'b0;
      branch_s     = 1'b0;
      instr_done_s = 1'b0;
      case (state_r)
         FETCH: begin
            alusrcb_s = 2'b01;
            irwrite_s = 1'b1;
            pcwrite_s = 1'b1;
         end
         DECODE: alusrcb_s = 2'b11;
         MEMADR, ADDIEX: begin
            alusrca_s = 1'b1;
            alusrcb_s = 2'b10;
         end
         MEMRD: iord_s = 1'b1;
         MEMWB: begin
            memtoreg_s   = 1'b1;
            regwrite_s   = 1'b1;
            instr_done_s = 1'b1;
         end
         MEMWR: begin
            iord_s       = 1'b1;
            memwrite_s   = 1'b1;
            instr_done_s = 1'b1;
         end
         EXEC: begin
            alusrca_s = 1'b1;
            aluctrl_s = funct_aluctrl(funct);
         end
         ALUWB: begin
            regdst_s     = 1'b1;
            regwrite_s   = 1'b1;
            instr_done_s = 1'b1;
         end
         BRANCH: begin
            alusrca_s    = 1'b1;
            aluctrl_s    = ALU_SUB;
            pcsrc_s      = 2'b01;
            branch_s     = 1'b1;
            instr_done_s = 1'b1;
         end
         ADDIWB: begin
            regwrite_s   = 1'b1;
            instr_done_s = 1'b1;
         end
         JUMP: begin
            pcsrc_s      = 2'b10;
            pcwrite_s    = 1'b1;
            instr_done_s = 1'b1;
         end
         default: aluctrl_s = ALU_ADD;
      endcase
   end

   // State register and retired-instruction counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= FETCH;
         instr_count_r <= {CNT_W{1'b0}};
      end else begin
         state_r <= state_nxt_s;
         if (instr_done_s) begin
            instr_count_r <= instr_count_r + CNT_ONE;
         end else begin
            instr_count_r <= instr_count_r;
         end
      end
   end

   // Write enables are held off for the whole time reset is asserted.
   assign IRWrite     = irwrite_s & rst_n;
   assign MemWrite    = memwrite_s & rst_n;
   assign RegWrite    = regwrite_s & rst_n;
   assign PCEn        = rst_n & (pcwrite_s | (branch_s & Zero));
   assign ALUctrl     = aluctrl_s;
   assign ALUSrcA     = alusrca_s;
   assign ALUSrcB     = alusrcb_s;
   assign PCSrc       = pcsrc_s;
   assign IorD        = iord_s;
   assign RegDst      = regdst_s;
   assign MemtoReg    = memtoreg_s;
   assign instr_done  = instr_done_s;
   assign illegal     = illegal_s;
   assign state       = state_r;
   assign instr_count = instr_count_r;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: a 32-bit-counter instance and a
// 4-bit-counter instance driven by the same instruction stream.
module tb_mips_multicycle_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic        Zero;

   logic [2:0]  ALUctrl;
   logic        ALUSrcA;
   logic [1:0]  ALUSrcB;
   logic [1:0]  PCSrc;
   logic        IorD, IRWrite, MemWrite, RegWrite, RegDst, MemtoReg, PCEn;
   logic        instr_done, illegal;
   logic [3:0]  state;
   logic [31:0] instr_count;

   logic [2:0]  b_aluctrl;
   logic        b_alusrca;
   logic [1:0]  b_alusrcb;
   logic [1:0]  b_pcsrc;
   logic        b_iord, b_irwrite, b_memwrite, b_regwrite, b_regdst, b_memtoreg, b_pcen;
   logic        b_done, b_illegal;
   logic [3:0]  b_state;
   logic [3:0]  b_count;

   int vectors = 0;
   int miscompares = 0;

   logic [5:0] fn_tab  [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
   logic [2:0] alu_tab [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};

   mips_multicycle_ctrl #(.CNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .Zero(Zero),
      .ALUctrl(ALUctrl), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc),
      .IorD(IorD), .IRWrite(IRWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
      .RegDst(RegDst), .MemtoReg(MemtoReg), .PCEn(PCEn), .instr_done(instr_done),
      .illegal(illegal), .state(state), .instr_count(instr_count)
   );

   mips_multicycle_ctrl #(.CNT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .Zero(Zero),
      .ALUctrl(b_aluctrl), .ALUSrcA(b_alusrca), .ALUSrcB(b_alusrcb), .PCSrc(b_pcsrc),
      .IorD(b_iord), .IRWrite(b_irwrite), .MemWrite(b_memwrite), .RegWrite(b_regwrite),
      .RegDst(b_regdst), .MemtoReg(b_memtoreg), .PCEn(b_pcen), .instr_done(b_done),
      .illegal(b_illegal), .state(b_state), .instr_count(b_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n  = 1'b0;
      opcode = 6'b000000;
      funct  = 6'b000000;
      Zero   = 1'b0;

      // Reset held across several edges
      repeat (3) @(posedge clk);
      #1;
      chk("rst_state", {28'd0, state}, 32'd0);
      chk("rst_irwrite", {31'd0, IRWrite}, 32'd0);
      chk("rst_pcen", {31'd0, PCEn}, 32'd0);
      chk("rst_regwrite", {31'd0, RegWrite}, 32'd0);
      chk("rst_memwrite", {31'd0, MemWrite}, 32'd0);
      chk("rst_count", instr_count, 32'd0);
      chk("rst_count4", {28'd0, b_count}, 32'd0);
      chk("rst_state4", {28'd0, b_state}, 32'd0);

      // Release: FETCH outputs appear
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("fetch_irwrite", {31'd0, IRWrite}, 32'd1);
      chk("fetch_pcen", {31'd0, PCEn}, 32'd1);
      chk("fetch_alusrcb", {30'd0, ALUSrcB}, 32'd1);
      chk("fetch_aluctrl", {29'd0, ALUctrl}, 32'd2);
      chk("fetch_iord", {31'd0, IorD}, 32'd0);

      // lw: 0,1,2,3,4; opcode garbage during MEMRD must not matter
      opcode = 6'b100011;
      cyc();
      chk("lw_s1", {28'd0, state}, 32'd1);
      chk("lw_dec_alusrcb", {30'd0, ALUSrcB}, 32'd3);
      chk("lw_dec_illegal", {31'd0, illegal}, 32'd0);
      cyc();
      chk("lw_s2", {28'd0, state}, 32'd2);
      chk("lw_adr_alusrca", {31'd0, ALUSrcA}, 32'd1);
      chk("lw_adr_alusrcb", {30'd0, ALUSrcB}, 32'd2);
      opcode = 6'b111111;
      cyc();
      chk("lw_s3", {28'd0, state}, 32'd3);
      chk("lw_rd_iord", {31'd0, IorD}, 32'd1);
      chk("lw_rd_regwrite", {31'd0, RegWrite}, 32'd0);
      chk("lw_rd_done", {31'd0, instr_done}, 32'd0);
      cyc();
      chk("lw_s4", {28'd0, state}, 32'd4);
      chk("lw_wb_regwrite", {31'd0, RegWrite}, 32'd1);
      chk("lw_wb_memtoreg", {31'd0, MemtoReg}, 32'd1);
      chk("lw_wb_done", {31'd0, instr_done}, 32'd1);
      chk("lw_wb_count", instr_count, 32'd0);
      cyc();
      chk("lw_end_state", {28'd0, state}, 32'd0);
      chk("lw_end_done", {31'd0, instr_done}, 32'd0);
      chk("lw_count", instr_count, 32'd1);

      // R-type sweep
      opcode = 6'b000000;
      for (int i = 0; i < 5; i++) begin
         funct = fn_tab[i];
         chk("r_s0", {28'd0, state}, 32'd0);
         cyc();
         chk("r_s1", {28'd0, state}, 32'd1);
         chk("r_illegal", {31'd0, illegal}, 32'd0);
         cyc();
         chk("r_s6", {28'd0, state}, 32'd6);
         chk("r_aluctrl", {29'd0, ALUctrl}, {29'd0, alu_tab[i]});
         chk("r_alusrcb", {30'd0, ALUSrcB}, 32'd0);
         cyc();
         chk("r_s7", {28'd0, state}, 32'd7);
         chk("r_regdst", {31'd0, RegDst}, 32'd1);
         chk("r_regwrite", {31'd0, RegWrite}, 32'd1);
         chk("r_memtoreg", {31'd0, MemtoReg}, 32'd0);
         cyc();
      end
      chk("r_count", instr_count, 32'd6);

      // beq taken, then Zero dropped inside BRANCH
      opcode = 6'b000100;
      Zero   = 1'b1;
      cyc();
      chk("beq1_s1", {28'd0, state}, 32'd1);
      cyc();
      chk("beq1_s8", {28'd0, state}, 32'd8);
      chk("beq1_pcen", {31'd0, PCEn}, 32'd1);
      chk("beq1_pcsrc", {30'd0, PCSrc}, 32'd1);
      chk("beq1_aluctrl", {29'd0, ALUctrl}, 32'd6);
      chk("beq1_done", {31'd0, instr_done}, 32'd1);
      Zero = 1'b0;
      #1;
      chk("beq1_pcen_comb", {31'd0, PCEn}, 32'd0);
      cyc();
      chk("beq1_end", {28'd0, state}, 32'd0);
      chk("beq1_count", instr_count, 32'd7);

      // beq not taken
      cyc();
      cyc();
      chk("beq0_s8", {28'd0, state}, 32'd8);
      chk("beq0_pcen", {31'd0, PCEn}, 32'd0);
      cyc();
      chk("beq0_end", {28'd0, state}, 32'd0);
      chk("beq0_count", instr_count, 32'd8);

      // Illegal opcode
      opcode = 6'b111111;
      cyc();
      chk("ill_op_s1", {28'd0, state}, 32'd1);
      chk("ill_op_pulse", {31'd0, illegal}, 32'd1);
      cyc();
      chk("ill_op_s0", {28'd0, state}, 32'd0);
      chk("ill_op_clear", {31'd0, illegal}, 32'd0);
      chk("ill_op_count", instr_count, 32'd8);

      // R-type with unsupported funct
      opcode = 6'b000000;
      funct  = 6'b000111;
      cyc();
      chk("ill_fn_pulse", {31'd0, illegal}, 32'd1);
      cyc();
      chk("ill_fn_s0", {28'd0, state}, 32'd0);
      chk("ill_fn_count", instr_count, 32'd8);

      // sw: 0,1,2,5
      opcode = 6'b101011;
      cyc();
      cyc();
      chk("sw_s2", {28'd0, state}, 32'd2);
      cyc();
      chk("sw_s5", {28'd0, state}, 32'd5);
      chk("sw_memwrite", {31'd0, MemWrite}, 32'd1);
      chk("sw_iord", {31'd0, IorD}, 32'd1);
      chk("sw_done", {31'd0, instr_done}, 32'd1);
      opcode = 6'b000000;
      cyc();
      chk("sw_end", {28'd0, state}, 32'd0);
      chk("sw_count", instr_count, 32'd9);

      // j: 0,1,11
      opcode = 6'b000010;
      cyc();
      cyc();
      chk("j_s11", {28'd0, state}, 32'd11);
      chk("j_pcsrc", {30'd0, PCSrc}, 32'd2);
      chk("j_pcen", {31'd0, PCEn}, 32'd1);
      cyc();
      chk("j_end", {28'd0, state}, 32'd0);
      chk("j_count", instr_count, 32'd10);
      chk("j_count4", {28'd0, b_count}, 32'd10);

      // Reset asserted during MEMRD of a lw
      opcode = 6'b100011;
      cyc();
      cyc();
      cyc();
      chk("abort_s3", {28'd0, state}, 32'd3);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_state", {28'd0, state}, 32'd0);
      chk("abort_regwrite", {31'd0, RegWrite}, 32'd0);
      chk("abort_irwrite", {31'd0, IRWrite}, 32'd0);
      chk("abort_count", instr_count, 32'd0);
      cyc();
      chk("abort_hold_state", {28'd0, state}, 32'd0);
      chk("abort_hold_regwrite", {31'd0, RegWrite}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("restart_irwrite", {31'd0, IRWrite}, 32'd1);

      // 17 addi: 0,1,9,10 each
      opcode = 6'b001000;
      cyc();
      cyc();
      chk("addi_s9", {28'd0, state}, 32'd9);
      chk("addi_alusrca", {31'd0, ALUSrcA}, 32'd1);
      chk("addi_alusrcb", {30'd0, ALUSrcB}, 32'd2);
      cyc();
      chk("addi_s10", {28'd0, state}, 32'd10);
      chk("addi_regwrite", {31'd0, RegWrite}, 32'd1);
      chk("addi_regdst", {31'd0, RegDst}, 32'd0);
      chk("addi_memtoreg", {31'd0, MemtoReg}, 32'd0);
      cyc();
      chk("addi_count1", instr_count, 32'd1);
      for (int i = 1; i < 17; i++) begin
         repeat (4) cyc();
         chk("addi_loop_state", {28'd0, state}, 32'd0);
         if (i == 15) begin
            chk("addi16_count", instr_count, 32'd16);
            chk("addi16_count4_wrap", {28'd0, b_count}, 32'd0);
         end
      end
      chk("addi17_count", instr_count, 32'd17);
      chk("addi17_count4", {28'd0, b_count}, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
